// File: rtl/axis_color_centroid.sv
// axis_color_centroid: per-frame centroid of threshold-matched pixels from an AXI-Stream camera feed
module axis_color_centroid #(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic [7:0]  r_min,
  input  logic [7:0]  g_max,
  input  logic [7:0]  b_max,
  output logic [8:0]  centroid_x,
  output logic [7:0]  centroid_y,
  output logic [16:0] pixel_count,
  output logic        found,
  output logic        result_valid,
  output logic        overrun
);
  localparam logic [8:0]  X_MAX   = 9'(IMG_W - 1);
  localparam logic [7:0]  Y_MAX   = 8'(IMG_H - 1);
  localparam logic [16:0] MIN_CNT = 17'(MIN_PIXELS);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state;
  logic [8:0] x, cx, nx;
  logic [7:0] y, cy, ny;
  logic [7:0] lr, lg, lb, tr, tg, tb;
  logic [24:0] x_acc, y_acc, nxa, nya, qx, qy, nqx, nqy;
  logic [16:0] count, ncnt, sc, rx, ry;
  logic [17:0] shx, shy, dx, dy;
  logic match, frame_end, gx, gy;
  logic [4:0] it;
  logic unused_bits;
  assign s_axis_tready = 1'b1;
  assign unused_bits = ^{s_axis_tdata[31:24], dx[17], dy[17]};
  always_comb begin
    tr = s_axis_tuser ? r_min : lr;
    tg = s_axis_tuser ? g_max : lg;
    tb = s_axis_tuser ? b_max : lb;
    cx = s_axis_tuser ? 9'd0 : x;
    cy = s_axis_tuser ? 8'd0 : y;
    match = s_axis_tdata[23:16] >= tr && s_axis_tdata[15:8] <= tg && s_axis_tdata[7:0] <= tb;
    nxa = (s_axis_tuser ? 25'd0 : x_acc) + (match ? 25'(cx) : 25'd0);
    nya = (s_axis_tuser ? 25'd0 : y_acc) + (match ? 25'(cy) : 25'd0);
    ncnt = (s_axis_tuser ? 17'd0 : count) + 17'(match);
    nx = s_axis_tlast ? 9'd0 : (cx == X_MAX ? cx : cx + 9'd1);
    ny = (s_axis_tlast && cy != Y_MAX) ? cy + 8'd1 : cy;
    frame_end = s_axis_tvalid && s_axis_tlast && cy == Y_MAX;
    shx = {rx, qx[24]};
    shy = {ry, qy[24]};
    dx = shx - {1'b0, sc};
    dy = shy - {1'b0, sc};
    gx = shx >= {1'b0, sc};
    gy = shy >= {1'b0, sc};
    nqx = {qx[23:0], gx};
    nqy = {qy[23:0], gy};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
      x_acc <= '0;
      y_acc <= '0;
      count <= '0;
      lr <= '0;
      lg <= '0;
      lb <= '0;
    end else if (s_axis_tvalid) begin
      x <= nx;
      y <= ny;
      x_acc <= nxa;
      y_acc <= nya;
      count <= ncnt;
      lr <= tr;
      lg <= tg;
      lb <= tb;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      it <= '0;
      sc <= '0;
      qx <= '0;
      qy <= '0;
      rx <= '0;
      ry <= '0;
      centroid_x <= '0;
      centroid_y <= '0;
      pixel_count <= '0;
      found <= 1'b0;
      result_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (frame_end) begin
        overrun <= overrun | (state != IDLE);
        sc <= ncnt;
        qx <= nxa;
        qy <= nya;
        rx <= '0;
        ry <= '0;
        it <= '0;
        if (ncnt >= MIN_CNT) begin
          state <= DIV;
        end else begin
          state <= DONE;
          result_valid <= 1'b1;
          pixel_count <= ncnt;
          found <= 1'b0;
        end
      end else if (state == DIV) begin
        rx <= gx ? dx[16:0] : shx[16:0];
        ry <= gy ? dy[16:0] : shy[16:0];
        qx <= nqx;
        qy <= nqy;
        it <= it + 5'd1;
        if (it == 5'd24) begin
          state <= DONE;
          result_valid <= 1'b1;
          centroid_x <= nqx[8:0];
          centroid_y <= nqy[7:0];
          pixel_count <= sc;
          found <= 1'b1;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_axis_color_centroid.sv
// tb_axis_color_centroid: directed frame vectors against two instances (MIN_PIXELS 1 and 16)
module tb_axis_color_centroid;
  typedef struct {int x0; int x1; int y0; int y1; int cnt; int cx; int cy;} vec_t;
  localparam logic [31:0] HIT = 32'hA5804040;
  localparam logic [31:0] MISS = 32'h007F0000;
  logic clk = 0, reset = 1;
  logic [31:0] tdata = '0;
  logic tvalid = 0, tuser = 0, tlast = 0;
  logic [7:0] r_min = 8'd128, g_max = 8'd64, b_max = 8'd64;
  logic rdy1, rdy16, f1, f16, rv1, rv16, ov1, ov16;
  logic [8:0] cx1, cx16;
  logic [7:0] cy1, cy16;
  logic [16:0] pc1, pc16;
  int checks = 0, failures = 0, rdy_low = 0;
  int lat1, lat16, n1, n16, k1x, k1y, k1c, k1f, k16x, k16y, k16c, k16f;
  int e1x = 0, e1y = 0, e16x = 0, e16y = 0;
  vec_t tbl[7];
  axis_color_centroid #(.MIN_PIXELS(1)) u1 (
    .clk(clk), .reset(reset), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(rdy1),
    .s_axis_tuser(tuser), .s_axis_tlast(tlast), .r_min(r_min), .g_max(g_max), .b_max(b_max),
    .centroid_x(cx1), .centroid_y(cy1), .pixel_count(pc1), .found(f1), .result_valid(rv1), .overrun(ov1)
  );
  axis_color_centroid u16 (
    .clk(clk), .reset(reset), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(rdy16),
    .s_axis_tuser(tuser), .s_axis_tlast(tlast), .r_min(r_min), .g_max(g_max), .b_max(b_max),
    .centroid_x(cx16), .centroid_y(cy16), .pixel_count(pc16), .found(f16), .result_valid(rv16), .overrun(ov16)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!rdy1 || !rdy16) rdy_low++;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [31:0] d, input logic u, input logic l, input bit gaps);
    while (gaps && $urandom_range(1, 0) == 1) begin
      tvalid = 0;
      tdata = $urandom;
      tuser = 1'($urandom_range(1, 0));
      tlast = 1'($urandom_range(1, 0));
      step();
    end
    tvalid = 1;
    tdata = d;
    tuser = u;
    tlast = l;
    step();
    tvalid = 0;
    tuser = 0;
    tlast = 0;
  endtask
  task automatic send_frame(input int x0, input int x1, input int y0, input int y1);
    r_min = 8'd128; g_max = 8'd64; b_max = 8'd64;
    for (int y = 0; y < 240; y++) begin
      int len;
      len = (y >= y0 && y <= y1) ? x1 + 1 : 1;
      for (int x = 0; x < len; x++) begin
        beat((y >= y0 && y <= y1 && x >= x0 && x <= x1) ? HIT : MISS, 1'(y == 0 && x == 0), 1'(x == len - 1), 0);
        r_min = 8'd255; g_max = 8'd0; b_max = 8'd0;
      end
    end
  endtask
  task automatic wait_result();
    lat1 = 0; lat16 = 0; n1 = 0; n16 = 0;
    for (int k = 1; k <= 40; k++) begin
      if (rv1) begin
        n1++;
        if (lat1 == 0) begin lat1 = k; k1x = cx1; k1y = cy1; k1c = pc1; k1f = f1; end
      end
      if (rv16) begin
        n16++;
        if (lat16 == 0) begin lat16 = k; k16x = cx16; k16y = cy16; k16c = pc16; k16f = f16; end
      end
      step();
    end
  endtask
  task automatic check_res(input string nm, input int cnt, input int cx, input int cy);
    if (cnt >= 1) begin e1x = cx; e1y = cy; end
    if (cnt >= 16) begin e16x = cx; e16y = cy; end
    chk({nm, "_lat_m1"}, lat1, cnt >= 1 ? 26 : 1);
    chk({nm, "_pulses_m1"}, n1, 1);
    chk({nm, "_count_m1"}, k1c, cnt);
    chk({nm, "_found_m1"}, k1f, int'(cnt >= 1));
    chk({nm, "_cx_m1"}, k1x, e1x);
    chk({nm, "_cy_m1"}, k1y, e1y);
    chk({nm, "_lat_m16"}, lat16, cnt >= 16 ? 26 : 1);
    chk({nm, "_pulses_m16"}, n16, 1);
    chk({nm, "_count_m16"}, k16c, cnt);
    chk({nm, "_found_m16"}, k16f, int'(cnt >= 16));
    chk({nm, "_cx_m16"}, k16x, e16x);
    chk({nm, "_cy_m16"}, k16y, e16y);
  endtask
  task automatic zero_chk(input string nm);
    chk({nm, "_tready1"}, rdy1, 1);
    chk({nm, "_tready16"}, rdy16, 1);
    chk({nm, "_outs1"}, {cx1, cy1, pc1, f1, rv1, ov1}, 0);
    chk({nm, "_outs16"}, {cx16, cy16, pc16, f16, rv16, ov16}, 0);
  endtask
  initial begin
    int n;
    tbl[0] = '{100, 100, 50, 50, 1, 100, 50};
    tbl[1] = '{200, 209, 100, 109, 100, 204, 104};
    tbl[2] = '{10, 14, 20, 22, 15, 12, 21};
    tbl[3] = '{0, 3, 236, 239, 16, 1, 237};
    tbl[4] = '{0, 3, 0, 3, 16, 1, 1};
    tbl[5] = '{1, 0, 1, 0, 0, 0, 0};
    tbl[6] = '{200, 209, 100, 109, 100, 204, 104};
    repeat (3) step();
    zero_chk("in_reset");
    reset = 0;
    step();
    zero_chk("post_reset");
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1);
      wait_result();
      check_res($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].cx, tbl[i].cy);
    end
    chk("no_overrun_m1", ov1, 0);
    send_frame(100, 100, 50, 50);
    repeat (9) step();
    beat(HIT, 0, 1, 0);
    wait_result();
    check_res("overrun", 2, 50, 144);
    chk("overrun_set_m1", ov1, 1);
    chk("overrun_clear_m16", ov16, 0);
    send_frame(100, 100, 50, 50);
    repeat (11) step();
    chk("overrun_sticky_m1", ov1, 1);
    reset = 1;
    #1;
    zero_chk("mid_div_reset");
    step();
    reset = 0;
    n = 0;
    repeat (40) begin
      if (rv1 || rv16) n++;
      step();
    end
    chk("abort_no_pulse", n, 0);
    e1x = 0; e1y = 0; e16x = 0; e16y = 0;
    send_frame(tbl[6].x0, tbl[6].x1, tbl[6].y0, tbl[6].y1);
    wait_result();
    check_res("after_abort", tbl[6].cnt, tbl[6].cx, tbl[6].cy);
    chk("overrun_cleared_m1", ov1, 0);
    r_min = 8'd128; g_max = 8'd64; b_max = 8'd64;
    for (int y = 0; y < 240; y++) begin
      if (y == 5) begin
        for (int i = 0; i < 330; i++) beat(i >= 319 ? HIT : MISS, 0, 1'(i == 329), 1);
      end else begin
        beat(MISS, 1'(y == 0), 1, 1);
      end
      r_min = 8'd255; g_max = 8'd0; b_max = 8'd0;
    end
    wait_result();
    check_res("x_saturate", 11, 319, 5);
    chk("tready_low_cycles", rdy_low, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
